zegar_licznik: RTL

ZEGAR_LICZNIK -- requirements
Module: zegar_licznik

---
 rtl/zegar_licznik.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/zegar_licznik.sv
// HH:MM wall clock advanced by a one-per-second tick, with debounced,
// auto-repeating hour/minute set buttons that override the tick path.

module zegar_licznik_btn #(
  parameter int DEB_CYC = 4,
  parameter int REP_CYC = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  output logic req_o
);

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int REP_W = (REP_CYC > 1) ? $clog2(REP_CYC) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_STABLE  = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_REPEAT       = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } btn_state_t;

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic [REP_W-1:0] rep_cnt_r;
  btn_state_t       state_r;
  btn_state_t       state_nxt_s;
  logic             rep_seen_r;
  logic             rep_seen_nxt_s;
  logic             held_s;
  logic             rep_hit_s;
  logic             first_s;
  logic             rep_req_s;

  assign held_s    = (state_r == ST_PRESSED) || (state_r == ST_REPEAT) ||
                     (state_r == ST_WAIT_RELEASE);
  assign rep_hit_s = held_s && deb_r && (rep_cnt_r == REP_LAST);
  assign req_o     = first_s || rep_req_s;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= button_i;
      sync2_r <= sync1_r;
    end
  end

  // Debounced level flips only after DEB_CYC consecutive disagreeing cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_r     <= 1'b0;
      deb_cnt_r <= {DEB_W{1'b0}};
    end else if (sync2_r != deb_r) begin
      if (deb_cnt_r == DEB_LAST) begin
        deb_r     <= sync2_r;
        deb_cnt_r <= {DEB_W{1'b0}};
      end else begin
        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end
    end else begin
      deb_cnt_r <= {DEB_W{1'b0}};
    end
  end

  // Repeat period counter, restarted by every request and whenever the press ends.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_cnt_r <= {REP_W{1'b0}};
    end else if (!held_s || !deb_r || rep_hit_s) begin
      rep_cnt_r <= {REP_W{1'b0}};
    end else begin
      rep_cnt_r <= rep_cnt_r + REP_W'(1);
    end
  end

  // Button state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      rep_seen_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rep_seen_r <= rep_seen_nxt_s;
    end
  end

  // Next state and request generation; rep_seen_r remembers PRESSED vs REPEAT across a bounce.
  always_comb begin
    state_nxt_s    = state_r;
    rep_seen_nxt_s = rep_seen_r;
    first_s        = 1'b0;
    rep_req_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_WAIT_STABLE: begin
        rep_seen_nxt_s = 1'b0;
        if (deb_r) begin
          state_nxt_s = ST_PRESSED;
          first_s     = 1'b1;
        end else if (sync2_r) begin
          state_nxt_s = ST_WAIT_STABLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRESSED, ST_REPEAT: begin
        if (!deb_r) begin
          state_nxt_s    = ST_IDLE;
          rep_seen_nxt_s = 1'b0;
        end else begin
          rep_req_s = rep_hit_s;
          if (rep_hit_s) begin
            rep_seen_nxt_s = 1'b1;
          end else begin
            rep_seen_nxt_s = rep_seen_r;
          end
          if (!sync2_r) begin
            state_nxt_s = ST_WAIT_RELEASE;
          end else if (rep_hit_s || rep_seen_r) begin
            state_nxt_s = ST_REPEAT;
          end else begin
            state_nxt_s = ST_PRESSED;
          end
        end
      end
      ST_WAIT_RELEASE: begin
        if (!deb_r) begin
          rep_seen_nxt_s = 1'b0;
          if (sync2_r) begin
            state_nxt_s = ST_WAIT_STABLE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          rep_req_s = rep_hit_s;
          if (rep_hit_s) begin
            rep_seen_nxt_s = 1'b1;
          end else begin
            rep_seen_nxt_s = rep_seen_r;
          end
          if (sync2_r) begin
            if (rep_hit_s || rep_seen_r) begin
              state_nxt_s = ST_REPEAT;
            end else begin
              state_nxt_s = ST_PRESSED;
            end
          end else begin
            state_nxt_s = ST_WAIT_RELEASE;
          end
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        rep_seen_nxt_s = 1'b0;
      end
    endcase
  end

endmodule

module zegar_licznik #(
  parameter int DEB_CYC = 4,
  parameter int REP_CYC = 50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       button_hr_i,
  input  logic       button_min_i,
  output logic [3:0] hr1,
  output logic [1:0] hr2,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic       min_pulse_o
);

  logic [5:0] sec_r;
  logic [7:0] min_r;
  logic [5:0] hr_r;
  logic       min_pulse_r;
  logic [5:0] sec_nxt_s;
  logic [7:0] min_nxt_s;
  logic [5:0] hr_nxt_s;
  logic       req_hr_s;
  logic       req_min_s;
  logic       tick_eff_s;
  logic       sec_wrap_s;
  logic       min_wrap_s;

  // {tens, units} BCD minutes plus one, wrapping 59 -> 00; out-of-range codes fold to 00.
  function automatic logic [7:0] min_inc(input logic [7:0] mm);
    logic [7:0] res;
    if (mm[3:0] >= 4'd9) begin
      res[3:0] = 4'd0;
      if (mm[7:4] >= 4'd5) begin
        res[7:4] = 4'd0;
      end else begin
        res[7:4] = mm[7:4] + 4'd1;
      end
    end else begin
      res[7:4] = (mm[7:4] > 4'd5) ? 4'd0 : mm[7:4];
      res[3:0] = mm[3:0] + 4'd1;
    end
    return res;
  endfunction

  // {tens, units} BCD hours plus one, wrapping 23 -> 00.
  function automatic logic [5:0] hr_inc(input logic [5:0] hh);
    logic [5:0] res;
    if ((hh[5:4] >= 2'd2) && (hh[3:0] >= 4'd3)) begin
      res = 6'd0;
    end else if (hh[3:0] >= 4'd9) begin
      res = {hh[5:4] + 2'd1, 4'd0};
    end else begin
      res = {hh[5:4], hh[3:0] + 4'd1};
    end
    return res;
  endfunction

  zegar_licznik_btn #(.DEB_CYC(DEB_CYC), .REP_CYC(REP_CYC)) u_btn_hr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .button_i (button_hr_i),
    .req_o    (req_hr_s)
  );

  zegar_licznik_btn #(.DEB_CYC(DEB_CYC), .REP_CYC(REP_CYC)) u_btn_min (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .button_i (button_min_i),
    .req_o    (req_min_s)
  );

  // A minute request swallows a coincident tick entirely.
  assign tick_eff_s = tick_i && !req_min_s;
  assign sec_wrap_s = tick_eff_s && (sec_r >= 6'd59);
  assign min_wrap_s = sec_wrap_s && (min_r[7:4] >= 4'd5) && (min_r[3:0] >= 4'd9);

  // Next time value: requests take priority over the tick path; hour carry is absorbed by an hour request.
  always_comb begin
    sec_nxt_s = sec_r;
    min_nxt_s = min_r;
    hr_nxt_s  = hr_r;
    if (req_min_s) begin
      sec_nxt_s = 6'd0;
      min_nxt_s = min_inc(min_r);
    end else if (tick_eff_s) begin
      if (sec_wrap_s) begin
        sec_nxt_s = 6'd0;
        min_nxt_s = min_inc(min_r);
      end else begin
        sec_nxt_s = sec_r + 6'd1;
        min_nxt_s = min_r;
      end
    end else begin
      sec_nxt_s = sec_r;
      min_nxt_s = min_r;
    end
    if (req_hr_s || min_wrap_s) begin
      hr_nxt_s = hr_inc(hr_r);
    end else begin
      hr_nxt_s = hr_r;
    end
  end

  // Time registers; these drive the outputs directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sec_r       <= 6'd0;
      min_r       <= 8'd0;
      hr_r        <= 6'd0;
      min_pulse_r <= 1'b0;
    end else begin
      sec_r       <= sec_nxt_s;
      min_r       <= min_nxt_s;
      hr_r        <= hr_nxt_s;
      min_pulse_r <= sec_wrap_s;
    end
  end

  assign hr1         = hr_r[3:0];
  assign hr2         = hr_r[5:4];
  assign min1        = min_r[3:0];
  assign min2        = min_r[7:4];
  assign min_pulse_o = min_pulse_r;

endmodule
